// File: rtl/register_file_2r1w.sv
// Register file with one write port and two registered read ports sharing one read enable.
// Optional macro REGFILE_WRITE_BYPASS_EN selects write-first collision behaviour; the default is read-first.
module register_file_2r1w #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic             q_valid
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wa_ok;
    logic             ra_a_ok;
    logic             ra_b_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Every address is in range when DEPTH fills the address space.
    generate
        if (DEPTH == (1 << AW)) begin : g_full_range
            assign wa_ok   = 1'b1;
            assign ra_a_ok = 1'b1;
            assign ra_b_ok = 1'b1;
        end else begin : g_partial_range
            assign wa_ok   = (wa   < AW'(DEPTH));
            assign ra_a_ok = (ra_a < AW'(DEPTH));
            assign ra_b_ok = (ra_b < AW'(DEPTH));
        end
    endgenerate

    always_comb begin
        // NOTE: defaults first so every path assigns rd_a/rd_b and no latch is inferred.
        rd_a = '0;
        rd_b = '0;
        if (ra_a_ok) rd_a = regs[ra_a];
        if (ra_b_ok) rd_b = regs[ra_b];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && wa_ok && (wa == ra_a)) rd_a = wd;
        if (we && wa_ok && (wa == ra_b)) rd_b = wd;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset too, because reads after reset must return zero.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            qa      <= '0;
            qb      <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= re;
            if (re) begin
                qa <= rd_a;
                qb <= rd_b;
            end
            if (we && wa_ok) begin
                regs[wa] <= wd;
            end
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench: a DEPTH=8 and a DEPTH=6 instance share stimulus and are compared
// every cycle against an array model, plus literal expectations from directed vectors.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic        re = 1'b0;
    logic [2:0]  ra_a = '0;
    logic [2:0]  ra_b = '0;

    logic [15:0] qa8, qb8, qa6, qb6;
    logic        qv8, qv6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_2r1w #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re),
        .ra_a(ra_a), .ra_b(ra_b), .qa(qa8), .qb(qb8), .q_valid(qv8)
    );

    register_file_2r1w #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re),
        .ra_a(ra_a), .ra_b(ra_b), .qa(qa6), .qb(qb6), .q_valid(qv6)
    );

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Model state, index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
    int          depth [2] = '{8, 6};
    logic [15:0] m   [2][8];
    logic [15:0] eqa [2];
    logic [15:0] eqb [2];
    logic        eqv [2];
    bit          live = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input int k, input logic [2:0] a);
        if (int'(a) >= depth[k]) return 16'h0;
        if (BYPASS && we && wa == a) return wd;
        return m[k][a];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) m[k][r] = 16'h0;
                eqa[k] = 16'h0;
                eqb[k] = 16'h0;
                eqv[k] = 1'b0;
            end else begin
                eqv[k] = re;
                if (re) begin
                    eqa[k] = model_read(k, ra_a);
                    eqb[k] = model_read(k, ra_b);
                end
                if (we && int'(wa) < depth[k]) m[k][wa] = wd;
            end
        end
        if (rst) live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("model qa d8", qa8, eqa[0]);
            check("model qb d8", qb8, eqb[0]);
            check("model qv d8", {15'b0, qv8}, {15'b0, eqv[0]});
            check("model qa d6", qa6, eqa[1]);
            check("model qb d6", qb6, eqb[1]);
            check("model qv d6", {15'b0, qv6}, {15'b0, eqv[1]});
        end
    end

    task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [15:0] d,
                        input logic rd, input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        rst = r; we = w; wa = a; wd = d; re = rd; ra_a = x; ra_b = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then read 3/7.
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset qv", {15'b0, qv8}, 16'h0);
        check("reset qa", qa8, 16'h0);
        step(0, 0, 0, 0, 1, 3, 7);
        check("post reset qa", qa8, 16'h0);
        check("post reset qb", qb8, 16'h0);
        check("post reset qv", {15'b0, qv8}, 16'h1);

        // Basic write/read, same address on both ports.
        step(0, 1, 5, 16'hA5A5, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 5);
        check("basic qa", qa8, 16'hA5A5);
        check("basic qb", qb8, 16'hA5A5);

        // Collision on port A; port B reads an unrelated register.
        step(0, 1, 2, 16'h1111, 0, 0, 0);
        step(0, 1, 2, 16'h2222, 1, 2, 5);
        check("collide qa", qa8, BYPASS ? 16'h2222 : 16'h1111);
        check("collide qb", qb8, 16'hA5A5);
        step(0, 0, 0, 0, 1, 2, 0);
        check("after collide qa", qa8, 16'h2222);

        // Collision on port B only.
        step(0, 1, 3, 16'h3333, 1, 1, 3);
        check("collide b qb", qb8, BYPASS ? 16'h3333 : 16'h0000);
        check("collide b qa", qa8, 16'h0000);

        // Hold on idle while writing elsewhere.
        step(0, 1, 4, 16'hBEEF, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4, 4);
        check("idle base qa", qa8, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 3'(i), 16'h1000 + 16'(i), 0, 1, 1);
            check("idle hold qa", qa8, 16'hBEEF);
            check("idle qv", {15'b0, qv8}, 16'h0);
        end

        // Out-of-range write and read on the DEPTH=6 instance.
        step(0, 1, 7, 16'hFFFF, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1, 7, 3'(i));
            check("oor qa d6", qa6, 16'h0);
            check("oor qa d8", qa8, 16'hFFFF);
        end
        step(0, 1, 6, 16'h7777, 1, 6, 6);
        check("oor bypass d6", qa6, 16'h0);
        step(0, 0, 0, 0, 1, 6, 4);
        check("oor read6 d8", qa8, 16'h7777);
        check("oor read6 d6", qa6, 16'h0);

        // Reset mid-operation discards write and read.
        step(1, 1, 1, 16'h1234, 1, 1, 1);
        check("rst mid qv", {15'b0, qv8}, 16'h0);
        check("rst mid qa", qa8, 16'h0);
        step(0, 0, 0, 0, 1, 1, 4);
        check("rst mid read1", qa8, 16'h0);
        check("rst mid read4", qb8, 16'h0);

        // Write in first cycle after reset; read issued just before reset.
        step(0, 0, 0, 0, 1, 2, 2);
        step(1, 0, 0, 0, 0, 0, 0);
        check("pre-rst read qv", {15'b0, qv8}, 16'h0);
        step(0, 1, 6, 16'h6666, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 6);
        check("first cycle write", qa8, 16'h6666);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of registers; legal range is 2..256.
REQ-003 The block SHALL derive localparam AW = ceil(log2(DEPTH)) as the address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port wa, input, AW bits: write address.
REQ-008 The block SHALL have port wd, input, WIDTH bits: write data.
REQ-009 The block SHALL have port re, input, 1 bit: read enable, shared by both read ports.
REQ-010 The block SHALL have port ra_a, input, AW bits: read address, port A.
REQ-011 The block SHALL have port ra_b, input, AW bits: read address, port B.
REQ-012 The block SHALL have port qa, output, WIDTH bits: registered read data, port A.
REQ-013 The block SHALL have port qb, output, WIDTH bits: registered read data, port B.
REQ-014 The block SHALL have port q_valid, output, 1 bit: qa/qb hold the data of a read issued in the previous cycle.

Function
REQ-015 The block SHALL hold DEPTH registers of WIDTH bits each.
REQ-016 When we=1 and wa<DEPTH at a rising edge, the block SHALL write wd into register[wa]; the new value is visible to reads issued from the next cycle onward.
REQ-017 When we=1 and wa>=DEPTH (non-power-of-2 DEPTH only), the block SHALL ignore the write with no side effect.
REQ-018 When re=1 at a rising edge, the block SHALL load qa with register[ra_a] and qb with register[ra_b]; read latency is exactly 1 cycle.
REQ-019 When re=1, the block SHALL set q_valid to 1 on the same edge; when re=0, it SHALL set q_valid to 0 and hold qa/qb at their previous values.
REQ-020 For a read address >= DEPTH, the block SHALL load zero into the affected output.
REQ-021 When ra_a equals ra_b, the block SHALL load identical values into qa and qb.
REQ-022 For a simultaneous write and read of the same address, the read data SHALL follow the Configuration rule (REQ-029/REQ-030).
REQ-023 The block SHALL have no combinational path from any input to any output.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL clear every register to zero.
REQ-025 When rst=1 at a rising edge, the block SHALL set qa=0, qb=0 and q_valid=0.
REQ-026 rst SHALL take priority over we and re; a write or read presented in a reset cycle SHALL be discarded.
REQ-027 In the first cycle after rst deasserts, the block SHALL accept writes and reads normally.
REQ-028 A read issued in the cycle before reset asserts SHALL NOT produce q_valid=1 after reset.

Configuration
REQ-029 With macro REGFILE_WRITE_BYPASS_EN defined, when we=1, re=1 and wa==ra_x (wa<DEPTH), the block SHALL load wd into the matching output (write-first); each port is bypassed independently.
REQ-030 Without REGFILE_WRITE_BYPASS_EN, the block SHALL return the pre-write register contents for the same case (read-first); the write still completes.

Verification
REQ-031 Reset, then read: rst=1 for 1 cycle, then re=1, ra_a=3, ra_b=7 -> next cycle qa=0, qb=0, q_valid=1.
REQ-032 Basic write/read: write wa=5 wd=16'hA5A5, next cycle re=1, ra_a=5 -> qa=16'hA5A5 one cycle later.
REQ-033 Write collision: register[2]=16'h1111, then same cycle we=1, wa=2, wd=16'h2222, re=1, ra_a=2 -> qa=16'h2222 with REGFILE_WRITE_BYPASS_EN, 16'h1111 without; a following read returns 16'h2222 in both builds.
REQ-034 Hold on idle: read gives qa=16'hBEEF, then re=0 for 3 cycles while writing other values -> qa stays 16'hBEEF, q_valid=0.
REQ-035 Out-of-range address: with DEPTH=6, write wa=7 wd=16'hFFFF, then read ra_a=7 and ra_b=0..5 -> qa=0 and all six registers unchanged.
REQ-036 Reset mid-operation: rst=1 in the same cycle as we=1, wa=1, wd=16'h1234 and re=1 -> next cycle q_valid=0; a later read of address 1 returns 0.
